// File: rtl/reset_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_pkg
//  Brief    : Shared state encoding and reset-cause codes for the reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HOLD        = 3'd1,
        ST_WAIT_ASSERT = 3'd2,
        ST_WAIT_REL    = 3'd3,
        ST_DONE        = 3'd4
    } rs_state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_ctrl_if
//  Brief    : Request, domain reset and status bundle of the reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface reset_seq_ctrl_if #(
    parameter int NUM_DOMAINS = 2
) ();

    logic                   sw_req;
    logic                   wdt_req;
    logic [NUM_DOMAINS-1:0] rst_out_n;
    logic [NUM_DOMAINS-1:0] rst_ack_n;
    logic                   busy;
    logic                   done;
    logic [1:0]             cause;
    logic                   timeout_err;

    modport master (
        input  sw_req,
        input  wdt_req,
        input  rst_ack_n,
        output rst_out_n,
        output busy,
        output done,
        output cause,
        output timeout_err
    );

    modport slave (
        output sw_req,
        output wdt_req,
        output rst_ack_n,
        input  rst_out_n,
        input  busy,
        input  done,
        input  cause,
        input  timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/reset_seq_ctrl_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bit
//  Brief    : Single-bit multi-flop synchronizer, clears to 0 on reset.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_ctrl
//  Brief    : Multi-domain reset sequencer: hold all, confirm entry, release in order.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS  = 2,
    parameter int PULSE_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 255,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic           clock,
    input  wire logic           reset,
    reset_seq_ctrl_if.master    bus
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, ACK_TIMEOUT)) + 1;
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    rs_state_t              r_state;
    logic [NUM_DOMAINS-1:0] r_rst_out_n;
    logic                   r_busy;
    logic                   r_done;
    logic [1:0]             r_cause;
    logic                   r_terr;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;

    logic [NUM_DOMAINS-1:0] w_ack_s;
    logic                   w_req;
    logic [1:0]             w_req_cause;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   w_abort;

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_ack_sync
        sync_bit #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clock),
            .rst     (reset),
            .i_async (bus.rst_ack_n[gi]),
            .o_sync  (w_ack_s[gi])
        );
    end

    assign w_req       = bus.sw_req | bus.wdt_req;
    assign w_req_cause = (bus.sw_req  ? CAUSE_SW  : CAUSE_POR)
                       | (bus.wdt_req ? CAUSE_WDT : CAUSE_POR);
    assign w_idx_nxt   = r_idx + 1'b1;
    // A new request after the hold phase throws away any partial release.
    assign w_abort     = w_req && ((r_state == ST_WAIT_ASSERT) ||
                                   (r_state == ST_WAIT_REL)    ||
                                   (r_state == ST_DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_rst_out_n <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cause     <= CAUSE_POR;
            r_terr      <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_HOLD;
                r_rst_out_n <= '0;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_cause     <= r_cause | w_req_cause;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_req) begin
                            r_state     <= ST_HOLD;
                            r_cause     <= w_req_cause;
                            r_terr      <= 1'b0;
                            r_rst_out_n <= '0;
                            r_cnt       <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (w_req) begin
                            r_cnt   <= '0;
                            r_cause <= r_cause | w_req_cause;
                        end else if (r_cnt == c_PULSE_LAST) begin
                            r_state <= ST_WAIT_ASSERT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_ASSERT: begin
                        if ((w_ack_s == '0) || (r_cnt == c_ACK_LAST)) begin
                            if (w_ack_s != '0) begin
                                r_terr <= 1'b1;
                            end
                            r_state        <= ST_WAIT_REL;
                            r_idx          <= '0;
                            r_rst_out_n[0] <= 1'b1;
                            r_cnt          <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_REL: begin
                        if (w_ack_s[r_idx] || (r_cnt == c_ACK_LAST)) begin
                            if (!w_ack_s[r_idx]) begin
                                r_terr <= 1'b1;
                            end
                            if (r_idx < c_IDX_LAST) begin
                                r_idx                  <= w_idx_nxt;
                                r_rst_out_n[w_idx_nxt] <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out_n   = r_rst_out_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cause       = r_cause;
    assign bus.timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_seq_ctrl
//  Brief    : Directed vector bench for reset_seq_ctrl with a depth-2 domain model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq_ctrl;

    localparam int N = 2;
    localparam int P = 16;
    localparam int A = 255;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] stuck = '0;
    logic [N-1:0] m_s0  = '0;
    logic [N-1:0] m_s1  = '0;

    reset_seq_ctrl_if #(.NUM_DOMAINS(N)) bus ();

    reset_seq_ctrl #(
        .NUM_DOMAINS  (N),
        .PULSE_CYCLES (P),
        .ACK_TIMEOUT  (A),
        .SYNC_STAGES  (S)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Each downstream domain: a 2-flop synchronizer echoing its reset input.
    always @(posedge clock) begin
        m_s0 <= bus.rst_out_n;
        m_s1 <= m_s0;
    end
    assign bus.rst_ack_n = m_s1 & ~stuck;

    typedef struct {
        string        name;
        logic         rst;
        logic         sw;
        logic         wdt;
        logic [N-1:0] stk;
        int           cyc;
        logic [N-1:0] e_out;
        logic         e_busy;
        logic         e_done;
        logic [1:0]   e_cause;
        logic         e_terr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    always @(negedge clock) begin
        if (bus.done === 1'b1) n_done++;
    end

    task automatic add(input string name, input logic rst, input logic sw, input logic wdt,
                       input logic [N-1:0] stk, input int cyc, input logic [N-1:0] e_out,
                       input logic e_busy, input logic e_done, input logic [1:0] e_cause,
                       input logic e_terr);
        vec_t v;
        v.name = name; v.rst = rst; v.sw = sw; v.wdt = wdt; v.stk = stk; v.cyc = cyc;
        v.e_out = e_out; v.e_busy = e_busy; v.e_done = e_done; v.e_cause = e_cause;
        v.e_terr = e_terr;
        vecs.push_back(v);
    endtask

    initial begin
        bus.sw_req  = 1'b0;
        bus.wdt_req = 1'b0;

        //   name             rst sw wdt stuck  cyc   out   busy done cause terr
        add("por_reset",      1, 0, 0, 2'b00,   3, 2'b00, 1, 0, 2'b00, 0);
        add("por_hold",       0, 0, 0, 2'b00,  16, 2'b00, 1, 0, 2'b00, 0);
        add("por_rel0",       0, 0, 0, 2'b00,   1, 2'b01, 1, 0, 2'b00, 0);
        add("por_rel0_wait",  0, 0, 0, 2'b00,   4, 2'b01, 1, 0, 2'b00, 0);
        add("por_rel1",       0, 0, 0, 2'b00,   1, 2'b11, 1, 0, 2'b00, 0);
        add("por_done",       0, 0, 0, 2'b00,   5, 2'b11, 1, 1, 2'b00, 0);
        add("por_idle",       0, 0, 0, 2'b00,   1, 2'b11, 0, 0, 2'b00, 0);
        add("sw_start",       0, 1, 0, 2'b00,   1, 2'b00, 1, 0, 2'b01, 0);
        add("sw_hold",        0, 0, 0, 2'b00,  16, 2'b00, 1, 0, 2'b01, 0);
        add("sw_rel0",        0, 0, 0, 2'b00,   1, 2'b01, 1, 0, 2'b01, 0);
        add("sw_rel1",        0, 0, 0, 2'b00,   5, 2'b11, 1, 0, 2'b01, 0);
        add("wdt_abort",      0, 0, 1, 2'b00,   1, 2'b00, 1, 0, 2'b11, 0);
        add("abort_hold",     0, 0, 0, 2'b00,  16, 2'b00, 1, 0, 2'b11, 0);
        add("abort_done",     0, 0, 0, 2'b00,  11, 2'b11, 1, 1, 2'b11, 0);
        add("abort_idle",     0, 0, 0, 2'b00,   1, 2'b11, 0, 0, 2'b11, 0);
        add("wdt_start",      0, 0, 1, 2'b10,   1, 2'b00, 1, 0, 2'b10, 0);
        add("stuck_rel1",     0, 0, 0, 2'b10,  22, 2'b11, 1, 0, 2'b10, 0);
        add("stuck_wait",     0, 0, 0, 2'b10, 254, 2'b11, 1, 0, 2'b10, 0);
        add("stuck_tmo",      0, 0, 0, 2'b10,   1, 2'b11, 1, 1, 2'b10, 1);
        add("stuck_idle",     0, 0, 0, 2'b10,   1, 2'b11, 0, 0, 2'b10, 1);
        add("held_start",     0, 1, 0, 2'b00,   1, 2'b00, 1, 0, 2'b01, 0);
        add("held_hold",      0, 1, 0, 2'b00,  30, 2'b00, 1, 0, 2'b01, 0);
        add("held_rel_hold",  0, 0, 0, 2'b00,  16, 2'b00, 1, 0, 2'b01, 0);
        add("held_rel0",      0, 0, 0, 2'b00,   1, 2'b01, 1, 0, 2'b01, 0);
        add("held_done",      0, 0, 0, 2'b00,  10, 2'b11, 1, 1, 2'b01, 0);
        add("held_idle",      0, 0, 0, 2'b00,   1, 2'b11, 0, 0, 2'b01, 0);
        add("both_start",     0, 1, 1, 2'b01,   1, 2'b00, 1, 0, 2'b11, 0);
        add("both_tmo0",      0, 0, 0, 2'b01, 272, 2'b11, 1, 0, 2'b11, 1);
        add("mid_reset",      1, 0, 0, 2'b00,   1, 2'b00, 1, 0, 2'b00, 0);
        add("rerun_hold",     0, 0, 0, 2'b00,  16, 2'b00, 1, 0, 2'b00, 0);
        add("rerun_done",     0, 0, 0, 2'b00,  11, 2'b11, 1, 1, 2'b00, 0);
        add("rerun_idle",     0, 0, 0, 2'b00,   1, 2'b11, 0, 0, 2'b00, 0);

        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            bus.sw_req  = vecs[i].sw;
            bus.wdt_req = vecs[i].wdt;
            stuck       = vecs[i].stk;
            repeat (vecs[i].cyc) @(negedge clock);
            n_vec++;
            if ({bus.rst_out_n, bus.busy, bus.done, bus.cause, bus.timeout_err} !==
                {vecs[i].e_out, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cause, vecs[i].e_terr}) begin
                n_bad++;
                $display("FAIL %s: got out=%b busy=%b done=%b cause=%b terr=%b, want out=%b busy=%b done=%b cause=%b terr=%b",
                         vecs[i].name, bus.rst_out_n, bus.busy, bus.done, bus.cause, bus.timeout_err,
                         vecs[i].e_out, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cause, vecs[i].e_terr);
            end
        end

        // Five sequences ran to completion; each must have produced a single done cycle.
        n_vec++;
        if (n_done != 5) begin
            n_bad++;
            $display("FAIL done_pulses: got %0d done cycles, want 5", n_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
